// File: rtl/home_actuator_driver.sv
// Actuator driver behind the home-automation FSM: door strikes, fire siren, window, HVAC.
// Optional feature: define ALARM_LATCH_EN to latch the siren until alarm_ack.
module home_actuator_driver #(
  parameter int unsigned DOOR_PULSE = 8,
  parameter int unsigned SIREN_HALF = 4,
  parameter int unsigned MIN_ON     = 32,
  parameter int unsigned DEAD_TIME  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cmd,
  input  logic [2:0] state_code,
`ifdef ALARM_LATCH_EN
  input  logic       alarm_ack,
`endif
  output logic       front_lock,
  output logic       rear_lock,
  output logic       siren,
  output logic       window_motor,
  output logic       heater_en,
  output logic       cooler_en,
  output logic       hvac_busy,
  output logic       fault
);

  localparam int unsigned DoorW  = (DOOR_PULSE > 1) ? $clog2(DOOR_PULSE) : 1;
  localparam int unsigned SirenW = (SIREN_HALF > 1) ? $clog2(SIREN_HALF) : 1;
  localparam int unsigned OnW    = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
  localparam int unsigned DeadW  = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  localparam logic [DoorW-1:0]  DoorLoad  = DoorW'(DOOR_PULSE - 1);
  localparam logic [SirenW-1:0] SirenLast = SirenW'(SIREN_HALF - 1);
  localparam logic [OnW-1:0]    OnLoad    = OnW'(MIN_ON - 1);
  localparam logic [DeadW-1:0]  DeadLoad  = DeadW'(DEAD_TIME - 1);

  typedef enum logic [1:0] {HvOff, HvHeat, HvCool, HvDead} hvac_e;

  logic              valid;
  logic [5:0]        pcmd;
  logic              siren_act;
  // Only the door bits need edge detection, so only they are remembered.
  logic [1:0]        prev_cmd;
  logic [1:0]        lock_q;
  logic [DoorW-1:0]  door_cnt_q [2];
  logic              siren_run_q;
  logic [SirenW-1:0] siren_ph_q;
  hvac_e             hvac_q;
  logic [OnW-1:0]    on_cnt_q;
  logic [DeadW-1:0]  dead_cnt_q;

  always_comb begin
    valid = 1'b0;
    if (state_code == 3'd0) begin
      valid = (cmd == 6'd0);
    end else if (state_code <= 3'd6) begin
      valid = (cmd == (6'd1 << (state_code - 3'd1)));
    end
    pcmd = valid ? cmd : 6'd0;
  end

`ifdef ALARM_LATCH_EN
  logic alarm_q;
  // Ack only clears the latch once the fire command itself has gone away.
  assign siren_act = pcmd[2] | (alarm_q & ~alarm_ack);

  always_ff @(posedge clk) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= siren_act;
  end
`else
  assign siren_act = pcmd[2];
`endif

  assign front_lock = lock_q[0];
  assign rear_lock  = lock_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cmd     <= '0;
      lock_q       <= '0;
      door_cnt_q   <= '{default: '0};
      siren        <= 1'b0;
      siren_run_q  <= 1'b0;
      siren_ph_q   <= '0;
      window_motor <= 1'b0;
      heater_en    <= 1'b0;
      cooler_en    <= 1'b0;
      hvac_busy    <= 1'b0;
      fault        <= 1'b0;
      hvac_q       <= HvOff;
      on_cnt_q     <= '0;
      dead_cnt_q   <= '0;
    end else begin
      fault        <= ~valid;
      prev_cmd     <= pcmd[1:0];
      window_motor <= pcmd[3];

      for (int i = 0; i < 2; i++) begin
        if (pcmd[i] && !prev_cmd[i]) begin
          lock_q[i]     <= 1'b1;
          door_cnt_q[i] <= DoorLoad;
        end else if (lock_q[i]) begin
          if (door_cnt_q[i] == '0) lock_q[i] <= 1'b0;
          else                     door_cnt_q[i] <= door_cnt_q[i] - DoorW'(1);
        end
      end

      if (!siren_act) begin
        siren       <= 1'b0;
        siren_run_q <= 1'b0;
        siren_ph_q  <= '0;
      end else if (!siren_run_q) begin
        siren       <= 1'b1;
        siren_run_q <= 1'b1;
        siren_ph_q  <= '0;
      end else if (siren_ph_q == SirenLast) begin
        siren      <= ~siren;
        siren_ph_q <= '0;
      end else begin
        siren_ph_q <= siren_ph_q + SirenW'(1);
      end

      case (hvac_q)
        HvOff: begin
          if (pcmd[4]) begin
            hvac_q    <= HvHeat;
            heater_en <= 1'b1;
            hvac_busy <= 1'b1;
            on_cnt_q  <= OnLoad;
          end else if (pcmd[5]) begin
            hvac_q    <= HvCool;
            cooler_en <= 1'b1;
            hvac_busy <= 1'b1;
            on_cnt_q  <= OnLoad;
          end
        end
        HvHeat: begin
          if (on_cnt_q == '0 && !pcmd[4]) begin
            hvac_q     <= HvDead;
            heater_en  <= 1'b0;
            dead_cnt_q <= DeadLoad;
          end else if (on_cnt_q != '0) begin
            on_cnt_q <= on_cnt_q - OnW'(1);
          end
        end
        HvCool: begin
          if (on_cnt_q == '0 && !pcmd[5]) begin
            hvac_q     <= HvDead;
            cooler_en  <= 1'b0;
            dead_cnt_q <= DeadLoad;
          end else if (on_cnt_q != '0) begin
            on_cnt_q <= on_cnt_q - OnW'(1);
          end
        end
        HvDead: begin
          if (dead_cnt_q == '0) begin
            hvac_q    <= HvOff;
            hvac_busy <= 1'b0;
          end else begin
            dead_cnt_q <= dead_cnt_q - DeadW'(1);
          end
        end
        default: begin
          hvac_q    <= HvOff;
          heater_en <= 1'b0;
          cooler_en <= 1'b0;
          hvac_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/home_actuator_driver.md
HOME_ACTUATOR_DRIVER -- requirements
Module: home_actuator_driver

Interface
REQ-001 Parameter DOOR_PULSE, 8: door-lock strike pulse length, in clk cycles.
REQ-002 Parameter SIREN_HALF, 4: siren half-period, in clk cycles.
REQ-003 Parameter MIN_ON, 32: minimum heater/cooler on-time, in clk cycles.
REQ-004 Parameter DEAD_TIME, 16: forced both-off gap after heater/cooler release, in clk cycles.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 cmd  input  6  one-hot command from home-automation FSM: bit0 front door, bit1 rear door, bit2 fire, bit3 window, bit4 heater, bit5 cooler; 0 = idle.
REQ-008 state_code  input  3  FSM display code: 0 idle, 1 FD, 2 RD, 3 FA, 4 W, 5 heater, 6 cooler.
REQ-009 alarm_ack  input  1  alarm acknowledge; present only with ALARM_LATCH_EN.
REQ-010 front_lock, rear_lock  output  1 each  door strike pulses.
REQ-011 siren  output  1  fire siren drive, toggling.
REQ-012 window_motor  output  1  window actuator enable.
REQ-013 heater_en, cooler_en  output  1 each  HVAC enables.
REQ-014 hvac_busy  output  1  high whenever the HVAC FSM is not OFF.
REQ-015 fault  output  1  command/state-code inconsistency flag.

Function
REQ-016 All outputs shall be registered; inputs sampled at edge E shall affect outputs from edge E onward, giving 1-cycle latency.
REQ-017 A sample shall be valid only if cmd is zero with state_code 0, or cmd has exactly bit n-1 set with state_code n (n = 1..6).
REQ-018 fault shall equal the invalidity of the most recent sample; an invalid sample shall be processed as cmd = 0.
REQ-019 The block shall keep prev_cmd, the last processed (validated) command, for edge detection.
REQ-020 A 0->1 transition of cmd[0] versus prev_cmd shall drive front_lock high for exactly DOOR_PULSE cycles; a new rising edge during a pulse shall restart the count.
REQ-021 rear_lock shall behave as in REQ-020, using cmd[1].
REQ-022 While cmd[2] is processed high, siren shall start high and toggle every SIREN_HALF cycles; once cmd[2] is processed low, siren shall be 0 on the next output update and its phase counter shall clear.
REQ-023 window_motor shall equal the processed cmd[3].
REQ-024 The HVAC FSM shall have four states: OFF, HEAT, COOL and DEAD.
REQ-025 In OFF, a processed cmd[4] shall enter HEAT and a processed cmd[5] shall enter COOL; entry shall load the on-time counter.
REQ-026 HEAT shall drive heater_en=1 and shall leave to DEAD only when cmd[4] is processed low and MIN_ON cycles have elapsed since entry; a cooler request during HEAT shall be ignored.
REQ-027 COOL shall be symmetric to HEAT, using cooler_en and cmd[5].
REQ-028 DEAD shall hold both enables at 0 for DEAD_TIME cycles and then go to OFF; any request shall be re-evaluated only in OFF.
REQ-029 heater_en and cooler_en shall never be high in the same cycle.
REQ-030 Counters shall be sized by $clog2 of their parameter and shall saturate, never wrap.

Reset
REQ-031 rst high at an edge shall force all outputs to 0, the HVAC FSM to OFF, and all counters, prev_cmd and alarm latch to 0, aborting any pulse in progress.
REQ-032 A cmd bit held high across reset shall be treated as a rising edge on the first processed sample after reset.

Configuration
REQ-033 With ALARM_LATCH_EN defined, a processed cmd[2] shall set an alarm latch that keeps siren toggling after cmd[2] drops, until alarm_ack is sampled high while cmd[2] is processed low.
REQ-034 With ALARM_LATCH_EN defined, alarm_ack sampled while cmd[2] is high shall be ignored.
REQ-035 Without ALARM_LATCH_EN, the alarm_ack port shall not exist and siren shall follow REQ-022 only.

Verification
REQ-036 cmd=000001/state_code=1 held 20 cycles after reset -> front_lock high for exactly 8 cycles starting 1 cycle after the first sample, then low.
REQ-037 cmd=000100/state_code=3 for 20 cycles -> siren pattern 1111 0000 1111 ...; cmd->0 -> siren 0 next cycle (latch off), or siren keeps toggling until alarm_ack=1 (latch on).
REQ-038 cmd=010000/state_code=5 for 3 cycles, then cmd=100000/state_code=6 -> heater_en high 32 cycles, then 16 cycles with both enables low, then OFF for 1 cycle, then cooler_en high; the enables never overlap.
REQ-039 cmd=000011/state_code=1, and separately cmd=000001/state_code=2 -> fault=1 one cycle later and all actuators behave as for idle.
REQ-040 rst asserted mid-door-pulse and during HEAT -> all outputs 0 at the next edge; cmd still high after rst drops -> a new 8-cycle pulse and HEAT re-entry.
